// File: rtl/rsa_pkg.sv
// Shared RSA definitions: default operand width and the common control-state enum.
package rsa_pkg;

   localparam int KEY_W_DEF = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } rsa_state_e;

endpackage

// File: rtl/rsa_mod_double.sv
// One modular doubling step: r = 2t mod n, valid for t < n.
module rsa_mod_double #(
   parameter int W = 8
) (
   input  logic [W-1:0] t,
   input  logic [W-1:0] n,
   output logic [W-1:0] r
);

   logic [W:0] dbl;
   logic [W:0] diff;

   // The carry-out of 2t must take part in the compare, so stay W+1 wide.
   assign dbl  = {t, 1'b0};
   assign diff = dbl - {1'b0, n};
   assign r    = (dbl >= {1'b0, n}) ? diff[W-1:0] : dbl[W-1:0];

endmodule

// File: rtl/rsa_prep.sv
// Montgomery-domain entry: o_t = a * 2^KEY_W mod N by repeated modular doubling.
// Define RSA_PREP_RADIX4_EN to do two doublings per cycle (half the latency).
module rsa_prep
   import rsa_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [KEY_W-1:0] i_a,
   input  logic [KEY_W-1:0] i_n,
   output logic [KEY_W-1:0] o_t,
   output logic             o_finished,
   output logic             o_busy
);

   localparam int CW = $clog2(KEY_W + 1);
`ifdef RSA_PREP_RADIX4_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif

   rsa_state_e       state, state_nxt;
   logic [CW-1:0]    cnt, cnt_inc;
   logic [KEY_W-1:0] t, n, t_step, t_load;
   logic             last;

   assign cnt_inc = cnt + CW'(STEP);
   assign last    = (cnt_inc == CW'(KEY_W));
   // Operand may be up to one modulus too large; one subtract brings it in range.
   assign t_load  = (i_a < i_n) ? i_a : i_a - i_n;
   assign o_busy  = (state != IDLE);

`ifdef RSA_PREP_RADIX4_EN
   logic [KEY_W-1:0] t_mid;

   rsa_mod_double #(.W(KEY_W)) u_dbl0 (.t(t),     .n(n), .r(t_mid));
   rsa_mod_double #(.W(KEY_W)) u_dbl1 (.t(t_mid), .n(n), .r(t_step));
`else
   rsa_mod_double #(.W(KEY_W)) u_dbl0 (.t(t),     .n(n), .r(t_step));
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = CALC;
         CALC:    if (last)    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt        <= '0;
         t          <= '0;
         n          <= '0;
         o_t        <= '0;
         o_finished <= 1'b0;
      end else begin
         o_finished <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  n   <= i_n;
                  t   <= t_load;
                  cnt <= '0;
               end
            end
            CALC: begin
               t   <= t_step;
               cnt <= cnt_inc;
               if (last) begin
                  o_t        <= t_step;
                  o_finished <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_prep.sv
// Randomized bench for rsa_prep: 8-bit instance for directed/boundary cases, 256-bit for wide random.
module tb_rsa_prep;

`ifdef RSA_PREP_RADIX4_EN
   localparam int LAT8   = 4;
   localparam int LAT256 = 128;
`else
   localparam int LAT8   = 8;
   localparam int LAT256 = 256;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         s8, f8, b8;
   logic [7:0]   a8, n8, t8;
   logic         s256, f256, b256;
   logic [255:0] a256, n256, t256;

   int vectors = 0;
   int miscompares = 0;

   rsa_prep #(.KEY_W(8)) u_dut8 (
      .i_clk(clk), .i_rst(rst), .i_start(s8), .i_a(a8), .i_n(n8),
      .o_t(t8), .o_finished(f8), .o_busy(b8)
   );

   rsa_prep #(.KEY_W(256)) u_dut256 (
      .i_clk(clk), .i_rst(rst), .i_start(s256), .i_a(a256), .i_n(n256),
      .o_t(t256), .o_finished(f256), .o_busy(b256)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Reference: reduce a, then multiply by 2^W, then reduce again.
   function automatic logic [7:0] ref8(input int a, input int n);
      return 8'(((a % n) * 256) % n);
   endfunction

   function automatic logic [255:0] ref256(input logic [255:0] a, input logic [255:0] n);
      logic [511:0] num;
      logic [511:0] md;
      num = {a % n, 256'b0};
      md  = num % {256'b0, n};
      return md[255:0];
   endfunction

   task automatic op8(input logic [7:0] a, input logic [7:0] n,
                      output logic [7:0] t, output int lat);
      repeat (2) @(negedge clk);
      a8 = a; n8 = n; s8 = 1'b1;
      @(posedge clk); #1 s8 = 1'b0;
      lat = -1;
      for (int k = 1; k <= LAT8 + 20; k++) begin
         @(posedge clk); #1;
         if (f8) begin lat = k; break; end
      end
      t = t8;
   endtask

   task automatic op256(input logic [255:0] a, input logic [255:0] n,
                        output logic [255:0] t, output int lat);
      repeat (2) @(negedge clk);
      a256 = a; n256 = n; s256 = 1'b1;
      @(posedge clk); #1 s256 = 1'b0;
      lat = -1;
      for (int k = 1; k <= LAT256 + 20; k++) begin
         @(posedge clk); #1;
         if (f256) begin lat = k; break; end
      end
      t = t256;
   endtask

   initial begin
      logic [7:0]   t, ra, rn;
      logic [255:0] wt, wa, wn;
      int           lat, nf, fin_k[3];
      logic [7:0]   b2b_a[3];
      logic [7:0]   b2b_e[3];

      rst = 1'b1; s8 = 1'b0; a8 = '0; n8 = 8'd13;
      s256 = 1'b0; a256 = '0; n256 = 256'd1;
      #12;
      chk("rst_t", 256'(t8), 256'd0);
      chk("rst_busy", 256'(b8), 256'd0);
      chk("rst_fin", 256'(f8), 256'd0);
      @(negedge clk); rst = 1'b0;

      // nominal and boundaries
      op8(8'd5, 8'd13, t, lat);
      chk("nom_t", 256'(t), 256'd6);
      chk("nom_lat", 256'(lat), 256'(LAT8));
      op8(8'd0, 8'd13, t, lat);   chk("a0_t", 256'(t), 256'd0);
      op8(8'd12, 8'd13, t, lat);  chk("a12_t", 256'(t), 256'd4);
      op8(8'd15, 8'd13, t, lat);  chk("a15_t", 256'(t), 256'd5);

      // start pulse while busy must be ignored
      repeat (2) @(negedge clk);
      a8 = 8'd5; n8 = 8'd13; s8 = 1'b1;
      @(posedge clk); #1 s8 = 1'b0;
      chk("bsy_e0", 256'(b8), 256'd1);
      nf = 0;
      for (int k = 1; k <= LAT8 + 6; k++) begin
         @(posedge clk); #1;
         if (k == 2) begin s8 = 1'b1; a8 = 8'd1; end
         if (k == 3) s8 = 1'b0;
         chk($sformatf("bsy_e%0d", k), 256'(b8), 256'(k <= LAT8));
         if (f8) begin
            nf++;
            chk("bsy_t", 256'(t8), 256'd6);
         end
      end
      chk("bsy_nfin", 256'(nf), 256'd1);

      // reset in the middle of a calculation
      repeat (2) @(negedge clk);
      a8 = 8'd9; n8 = 8'd13; s8 = 1'b1;
      @(posedge clk); #1 s8 = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_t", 256'(t8), 256'd0);
      chk("mid_busy", 256'(b8), 256'd0);
      chk("mid_fin", 256'(f8), 256'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      nf = 0;
      for (int k = 0; k < LAT8 + 6; k++) begin
         @(posedge clk); #1;
         if (f8) nf++;
      end
      chk("mid_nofin", 256'(nf), 256'd0);
      op8(8'd5, 8'd13, t, lat);
      chk("mid_fresh", 256'(t), 256'd6);

      // start held high: one IDLE cycle between operations
      b2b_a[0] = 8'd5; b2b_a[1] = 8'd7; b2b_a[2] = 8'd12;
      for (int i = 0; i < 3; i++) b2b_e[i] = ref8(int'(b2b_a[i]), 13);
      repeat (2) @(negedge clk);
      a8 = b2b_a[0]; n8 = 8'd13; s8 = 1'b1;
      @(posedge clk); #1;
      nf = 0;
      for (int k = 1; k <= 3 * (LAT8 + 2) + 20 && nf < 3; k++) begin
         @(posedge clk); #1;
         if (f8) begin
            chk($sformatf("b2b_t%0d", nf), 256'(t8), 256'(b2b_e[nf]));
            fin_k[nf] = k;
            nf++;
            if (nf < 3) a8 = b2b_a[nf];
            else        s8 = 1'b0;
         end
      end
      s8 = 1'b0;
      chk("b2b_nfin", 256'(nf), 256'd3);
      if (nf == 3) begin
         chk("b2b_first", 256'(fin_k[0]), 256'(LAT8));
         chk("b2b_gap1", 256'(fin_k[1] - fin_k[0]), 256'(LAT8 + 2));
         chk("b2b_gap2", 256'(fin_k[2] - fin_k[1]), 256'(LAT8 + 2));
      end

      // random 8-bit, operand may exceed modulus
      for (int i = 0; i < 60; i++) begin
         rn = 8'($urandom_range(128, 255)) | 8'd1;
         ra = 8'($urandom_range(0, 255));
         op8(ra, rn, t, lat);
         chk($sformatf("r8_t a=%0d n=%0d", ra, rn), 256'(t), 256'(ref8(int'(ra), int'(rn))));
         chk("r8_lat", 256'(lat), 256'(LAT8));
      end

      // random 256-bit, a < N
      for (int i = 0; i < 30; i++) begin
         for (int w = 0; w < 8; w++) begin
            wn[w*32 +: 32] = $urandom;
            wa[w*32 +: 32] = $urandom;
         end
         wn[0] = 1'b1;
         wn[255] = 1'b1;
         wa = wa % wn;
         op256(wa, wn, wt, lat);
         chk($sformatf("r256_t%0d", i), wt, ref256(wa, wn));
         chk("r256_lat", 256'(lat), 256'(LAT256));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
